// File: rtl/wb_shared_arb_bus_pkg.sv
// Shared definitions for the shared-bus Wishbone arbiter/decoder.
package wb_shared_arb_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY     = 2'd1,
    ST_ERR_RESP = 2'd2
  } wb_state_e;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Width of an index register for n entries, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin request picker with a last-grant pointer that advances on release.
module wb_rr_arbiter
  import wb_shared_arb_bus_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [N-1:0] req_i,
  input  logic         adv_i,
  input  logic [N-1:0] adv_gnt_i,
  output logic [N-1:0] gnt_o
);

  localparam int PW = idx_width(N);

  logic [PW-1:0] last_q;
  logic [PW-1:0] last_d;
  logic          pick_found;

  // Search starts one past the last released master and wraps around.
  always_comb begin
    gnt_o      = '0;
    pick_found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!pick_found && req_i[j] && (j == (int'(last_q) + i) % N)) begin
          gnt_o[j]   = 1'b1;
          pick_found = 1'b1;
        end
      end
    end
  end

  // On release the pointer moves to the master that just finished.
  always_comb begin
    last_d = last_q;
    if (adv_i) begin
      for (int j = 0; j < N; j++) begin
        if (adv_gnt_i[j]) last_d = PW'(j);
      end
    end
  end

  // Pointer register; reset so that master 0 is searched first.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= PW'(N - 1);
    end else if (en_i) begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/wb_shared_arb_bus.sv
// Multi-master shared Wishbone bus: round-robin grant, address decode,
// unmapped-address and timeout error responses.
module wb_shared_arb_bus
  import wb_shared_arb_bus_pkg::*;
#(
  parameter int WB_N_MASTERS_g = 2,
  parameter int WB_N_SLAVES_g  = 4,
  parameter int WB_AWIDTH_g    = 16,
  parameter int WB_DWIDTH_g    = 8,
  parameter logic [WB_N_SLAVES_g*WB_AWIDTH_g-1:0] WB_BASEADDR_g =
    {16'h0030, 16'h0020, 16'h0010, 16'h0000},
  parameter logic [WB_N_SLAVES_g*WB_AWIDTH_g-1:0] WB_SIZE_g = {4{16'h0010}},
  parameter int WB_TIMEOUT_g   = 15
) (
  input  logic                                  CLK_i,
  input  logic                                  RST_i,
  input  logic                                  CLK_EN_i,
  input  logic [WB_N_MASTERS_g*WB_AWIDTH_g-1:0] WBM_ADR_i,
  input  logic [WB_N_MASTERS_g*WB_DWIDTH_g-1:0] WBM_DAT_i,
  input  logic [WB_N_MASTERS_g*(WB_DWIDTH_g/8)-1:0] WBM_SEL_i,
  input  logic [WB_N_MASTERS_g-1:0]             WBM_WE_i,
  input  logic [WB_N_MASTERS_g-1:0]             WBM_STB_i,
  input  logic [WB_N_MASTERS_g-1:0]             WBM_CYC_i,
  output logic [WB_DWIDTH_g-1:0]                WBM_DAT_o,
  output logic [WB_N_MASTERS_g-1:0]             WBM_ACK_o,
  output logic [WB_N_MASTERS_g-1:0]             WBM_ERR_o,
  output logic [WB_N_MASTERS_g-1:0]             WBM_RTY_o,
  output logic [WB_N_MASTERS_g-1:0]             WBM_GNT_o,
  output logic [WB_AWIDTH_g-1:0]                WBS_ADR_o,
  output logic [WB_DWIDTH_g-1:0]                WBS_DAT_o,
  output logic [(WB_DWIDTH_g/8)-1:0]            WBS_SEL_o,
  output logic                                  WBS_WE_o,
  output logic [WB_N_SLAVES_g-1:0]              WBS_STB_o,
  output logic [WB_N_SLAVES_g-1:0]              WBS_CYC_o,
  input  logic [WB_N_SLAVES_g*WB_DWIDTH_g-1:0]  WBS_DAT_i,
  input  logic [WB_N_SLAVES_g-1:0]              WBS_ACK_i,
  input  logic [WB_N_SLAVES_g-1:0]              WBS_ERR_i,
  input  logic [WB_N_SLAVES_g-1:0]              WBS_RTY_i
);

  localparam int NM = WB_N_MASTERS_g;
  localparam int NS = WB_N_SLAVES_g;
  localparam int AW = WB_AWIDTH_g;
  localparam int DW = WB_DWIDTH_g;
  localparam int SW = WB_DWIDTH_g / 8;
  localparam int TW = clog2(WB_TIMEOUT_g + 1);
  // Counter value seen during the last strobed cycle before expiry.
  localparam logic [TW-1:0] TO_LAST = TW'(WB_TIMEOUT_g - 1);

  wb_state_e     state_q;
  logic [NM-1:0] gnt_q;
  logic [TW-1:0] cnt_q;
  logic [NM-1:0] arb_gnt;

  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_dat;
  logic [SW-1:0] m_sel;
  logic          m_we, m_stb, m_cyc;

  logic [NS-1:0] hit_raw, hit_vec;
  logic [AW-1:0] win_mask [NS];
  logic [AW-1:0] win_sel_mask;
  logic          hit_any;

  logic [DW-1:0] s_dat;
  logic          s_ack, s_err, s_rty, s_term;
  logic          in_err;
  logic          release_cyc;

  // Select the granted master's request signals; zero when nobody holds the bus.
  always_comb begin
    m_adr = '0;
    m_dat = '0;
    m_sel = '0;
    m_we  = 1'b0;
    m_stb = 1'b0;
    m_cyc = 1'b0;
    for (int m = 0; m < NM; m++) begin
      if (gnt_q[m]) begin
        m_adr = WBM_ADR_i[m*AW +: AW];
        m_dat = WBM_DAT_i[m*DW +: DW];
        m_sel = WBM_SEL_i[m*SW +: SW];
        m_we  = WBM_WE_i[m];
        m_stb = WBM_STB_i[m];
        m_cyc = WBM_CYC_i[m];
      end
    end
  end

  // Per-slave window match on the granted address.
  generate
    for (genvar gi = 0; gi < NS; gi++) begin : g_dec
      localparam logic [AW-1:0] BASE = WB_BASEADDR_g[gi*AW +: AW];
      localparam logic [AW-1:0] MASK = WB_SIZE_g[gi*AW +: AW] - AW'(1);
      assign win_mask[gi] = MASK;
      assign hit_raw[gi]  = ((m_adr & ~MASK) == BASE);
    end
  endgenerate

  // Overlapping windows resolve to the lowest slave index.
  always_comb begin
    hit_vec      = '0;
    win_sel_mask = '0;
    hit_any      = 1'b0;
    if (|gnt_q) begin
      for (int s = 0; s < NS; s++) begin
        if (hit_raw[s] && !hit_any) begin
          hit_vec[s]   = 1'b1;
          win_sel_mask = win_mask[s];
          hit_any      = 1'b1;
        end
      end
    end
  end

  // Return path from the decoded slave.
  always_comb begin
    s_dat = '0;
    s_ack = 1'b0;
    s_err = 1'b0;
    s_rty = 1'b0;
    for (int s = 0; s < NS; s++) begin
      if (hit_vec[s]) begin
        s_dat = WBS_DAT_i[s*DW +: DW];
        s_ack = WBS_ACK_i[s];
        s_err = WBS_ERR_i[s];
        s_rty = WBS_RTY_i[s];
      end
    end
  end

  assign in_err      = (state_q == ST_ERR_RESP);
  assign s_term      = s_ack | s_err | s_rty;
  assign release_cyc = (state_q == ST_BUSY) && !m_cyc;

  // The error-response cycle hides the slave so a stalled slave is cut off.
  assign WBS_ADR_o = hit_any ? (m_adr & win_sel_mask) : '0;
  assign WBS_DAT_o = m_dat;
  assign WBS_SEL_o = m_sel;
  assign WBS_WE_o  = m_we;
  assign WBS_STB_o = hit_vec & {NS{m_stb & ~in_err}};
  assign WBS_CYC_o = hit_vec & {NS{m_cyc & ~in_err}};

  assign WBM_DAT_o = s_dat;
  assign WBM_ACK_o = gnt_q & {NM{s_ack & ~in_err}};
  assign WBM_ERR_o = gnt_q & {NM{(s_err & ~in_err) | in_err}};
  assign WBM_RTY_o = gnt_q & {NM{s_rty & ~in_err}};
  assign WBM_GNT_o = gnt_q;

  wb_rr_arbiter #(
    .N(NM)
  ) u_arb (
    .clk_i    (CLK_i),
    .rst_i    (RST_i),
    .en_i     (CLK_EN_i),
    .req_i    (WBM_CYC_i),
    .adv_i    (release_cyc),
    .adv_gnt_i(gnt_q),
    .gnt_o    (arb_gnt)
  );

  // Bus ownership FSM with the strobe-wait timeout counter.
  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else if (CLK_EN_i) begin
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (|WBM_CYC_i) begin
            gnt_q   <= arb_gnt;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!m_cyc) begin
            gnt_q   <= '0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else if (m_stb && !hit_any) begin
            cnt_q   <= '0;
            state_q <= ST_ERR_RESP;
          end else if (m_stb && !s_term) begin
            if (cnt_q == TO_LAST) begin
              cnt_q   <= '0;
              state_q <= ST_ERR_RESP;
            end else begin
              cnt_q <= cnt_q + TW'(1);
            end
          end else begin
            // A slave termination beats a simultaneous expiry.
            cnt_q <= '0;
          end
        end
        ST_ERR_RESP: begin
          cnt_q   <= '0;
          state_q <= ST_BUSY;
        end
        default: begin
          gnt_q   <= '0;
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_shared_arb_bus.sv
// Directed and randomized checks of the shared Wishbone bus.
module tb_wb_shared_arb_bus;

  localparam int NM = 2;
  localparam int NS = 4;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic [31:0] wbm_adr;
  logic [15:0] wbm_dat;
  logic [1:0]  wbm_sel;
  logic [1:0]  wbm_we, wbm_stb, wbm_cyc;
  logic [7:0]  wbm_dat_o;
  logic [1:0]  wbm_ack_o, wbm_err_o, wbm_rty_o, wbm_gnt_o;
  logic [15:0] wbs_adr_o;
  logic [7:0]  wbs_dat_o;
  logic [0:0]  wbs_sel_o;
  logic        wbs_we_o;
  logic [3:0]  wbs_stb_o, wbs_cyc_o;
  logic [31:0] wbs_dat_i;
  logic [3:0]  wbs_ack_i, wbs_err_i, wbs_rty_i;
  logic [49:0] all_outs;

  int checks = 0;
  int errors = 0;

  // Memory map as the bench sees it.
  int base_t [NS] = '{32'h00, 32'h10, 32'h20, 32'h30};
  int size_t [NS] = '{32'h10, 32'h10, 32'h10, 32'h10};

  always #5 clk = ~clk;

  assign all_outs = {wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o, wbm_gnt_o,
                     wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_stb_o, wbs_cyc_o};

  wb_shared_arb_bus dut (
    .CLK_i(clk), .RST_i(rst), .CLK_EN_i(clk_en),
    .WBM_ADR_i(wbm_adr), .WBM_DAT_i(wbm_dat), .WBM_SEL_i(wbm_sel),
    .WBM_WE_i(wbm_we), .WBM_STB_i(wbm_stb), .WBM_CYC_i(wbm_cyc),
    .WBM_DAT_o(wbm_dat_o), .WBM_ACK_o(wbm_ack_o), .WBM_ERR_o(wbm_err_o),
    .WBM_RTY_o(wbm_rty_o), .WBM_GNT_o(wbm_gnt_o),
    .WBS_ADR_o(wbs_adr_o), .WBS_DAT_o(wbs_dat_o), .WBS_SEL_o(wbs_sel_o),
    .WBS_WE_o(wbs_we_o), .WBS_STB_o(wbs_stb_o), .WBS_CYC_o(wbs_cyc_o),
    .WBS_DAT_i(wbs_dat_i), .WBS_ACK_i(wbs_ack_i), .WBS_ERR_i(wbs_err_i),
    .WBS_RTY_i(wbs_rty_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode: the slave whose window contains adr, lowest index first.
  function automatic int ref_slave(input int adr);
    for (int s = 0; s < NS; s++) begin
      if (adr / size_t[s] == base_t[s] / size_t[s]) return s;
    end
    return -1;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Master 1 strobes slave 1, which never answers; optional clock-enable gap.
  task automatic run_timeout(input string tag, input int frz_start, input int frz_len);
    int exp_c;
    exp_c = TIMEOUT + 1 + frz_len;
    wbm_adr[31:16] = 16'h0015;
    wbm_stb        = 2'b10;
    for (int c = 1; c <= exp_c; c++) begin
      clk_en = !(c >= frz_start && c < frz_start + frz_len);
      #1;
      chk({tag, "_err"}, wbm_err_o, (c == exp_c) ? 2'b10 : 2'b00);
      chk({tag, "_stb"}, wbs_stb_o, (c == exp_c) ? 4'b0000 : 4'b0010);
      if (c == exp_c) begin
        wbm_stb = 2'b00;
        clk_en  = 1'b1;
      end
      next_cycle();
    end
    chk({tag, "_after_err"}, wbm_err_o, 2'b00);
    chk({tag, "_after_gnt"}, wbm_gnt_o, 2'b10);
    $display("timeout %s: expiry expected in strobed cycle %0d", tag, exp_c);
  endtask

  initial begin
    int sidx;
    int adr;

    // Reset with garbage on every input.
    rst       = 1'b1;
    clk_en    = 1'b1;
    wbm_adr   = $urandom;
    wbm_dat   = 16'($urandom);
    wbm_sel   = 2'($urandom);
    wbm_we    = 2'($urandom);
    wbm_stb   = 2'($urandom);
    wbm_cyc   = 2'b11;
    wbs_dat_i = $urandom;
    wbs_ack_i = 4'($urandom);
    wbs_err_i = 4'($urandom);
    wbs_rty_i = 4'($urandom);
    next_cycle();
    next_cycle();
    chk("reset_outs", all_outs, 50'd0);

    // Release with both masters requesting: master 0 first, then master 1.
    rst       = 1'b0;
    wbm_stb   = 2'b00;
    wbs_ack_i = '0;
    wbs_err_i = '0;
    wbs_rty_i = '0;
    #1;
    chk("post_reset_outs", all_outs, 50'd0);
    next_cycle();
    chk("gnt_m0_first", wbm_gnt_o, 2'b01);
    wbm_cyc = 2'b10;
    next_cycle();
    chk("gnt_idle_gap", wbm_gnt_o, 2'b00);
    next_cycle();
    chk("gnt_m1_second", wbm_gnt_o, 2'b10);
    $display("arbitration: grant 01 then 10");

    // Read from slave 2 at 0x0023.
    wbm_adr[31:16]  = 16'h0023;
    wbm_we          = 2'b00;
    wbm_stb         = 2'b10;
    wbs_dat_i       = 32'h1234_5678;
    wbs_dat_i[23:16] = 8'hA5;
    wbs_ack_i       = 4'b0100;
    #1;
    chk("rd_stb", wbs_stb_o, 4'b0100);
    chk("rd_adr", wbs_adr_o, 16'h0003);
    chk("rd_dat", wbm_dat_o, 8'hA5);
    chk("rd_ack", wbm_ack_o, 2'b10);
    next_cycle();
    wbm_stb   = 2'b00;
    wbs_ack_i = '0;
    $display("read 0x0023 from slave 2");

    // Unmapped address 0x0050.
    wbm_adr[31:16] = 16'h0050;
    wbm_stb        = 2'b10;
    #1;
    chk("unmap_stb", wbs_stb_o, 4'b0000);
    chk("unmap_err_pre", wbm_err_o, 2'b00);
    next_cycle();
    chk("unmap_err", wbm_err_o, 2'b10);
    chk("unmap_stb_err", wbs_stb_o, 4'b0000);
    wbm_stb = 2'b00;
    next_cycle();
    chk("unmap_err_done", wbm_err_o, 2'b00);
    chk("unmap_gnt", wbm_gnt_o, 2'b10);
    $display("unmapped access 0x0050");

    run_timeout("to_plain", 0, 0);
    run_timeout("to_frozen", 5, 5);

    // Random routing checks while master 1 holds the bus.
    for (int n = 0; n < 40; n++) begin
      adr       = int'($urandom_range(0, 16'h7F));
      wbm_adr   = {16'(adr), 16'($urandom)};
      wbm_dat   = 16'($urandom);
      wbm_sel   = 2'($urandom);
      wbm_we    = 2'($urandom);
      wbm_stb   = 2'b10;
      wbm_cyc   = {1'b1, 1'($urandom)};
      wbs_dat_i = $urandom;
      wbs_ack_i = 4'($urandom);
      wbs_err_i = 4'($urandom);
      wbs_rty_i = 4'($urandom);
      sidx      = ref_slave(adr);
      #1;
      chk("rnd_stb", wbs_stb_o, (sidx >= 0) ? (4'b1 << sidx) : 4'b0);
      chk("rnd_cyc", wbs_cyc_o, (sidx >= 0) ? (4'b1 << sidx) : 4'b0);
      chk("rnd_sadr", wbs_adr_o, (sidx >= 0) ? 16'(adr % size_t[sidx]) : 16'h0);
      chk("rnd_sdat", wbs_dat_o, wbm_dat[15:8]);
      chk("rnd_ssel", wbs_sel_o, wbm_sel[1]);
      chk("rnd_swe", wbs_we_o, wbm_we[1]);
      chk("rnd_mdat", wbm_dat_o, (sidx >= 0) ? wbs_dat_i[sidx*8 +: 8] : 8'h0);
      chk("rnd_ack", wbm_ack_o, (sidx >= 0 && wbs_ack_i[sidx]) ? 2'b10 : 2'b00);
      chk("rnd_err", wbm_err_o, (sidx >= 0 && wbs_err_i[sidx]) ? 2'b10 : 2'b00);
      chk("rnd_rty", wbm_rty_o, (sidx >= 0 && wbs_rty_i[sidx]) ? 2'b10 : 2'b00);
      $display("txn %0d: adr=%04h slave=%0d", n, adr, sidx);
      wbm_stb   = 2'b00;
      wbs_ack_i = '0;
      wbs_err_i = '0;
      wbs_rty_i = '0;
      next_cycle();
    end

    // Reset in the middle of an access whose ACK is already pending.
    wbm_cyc        = 2'b11;
    wbm_adr[31:16] = 16'h0005;
    wbm_stb        = 2'b10;
    wbs_ack_i      = 4'b0001;
    #1;
    chk("pend_ack", wbm_ack_o, 2'b10);
    rst = 1'b1;
    #1;
    chk("midrst_outs", all_outs, 50'd0);
    next_cycle();
    rst = 1'b0;
    #1;
    chk("midrst_release_outs", all_outs, 50'd0);
    next_cycle();
    chk("midrst_m0_first", wbm_gnt_o, 2'b01);
    $display("mid-access reset, master 0 regains bus");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_shared_arb_bus.md
WB_SHARED_ARB_BUS -- requirements
Module: wb_shared_arb_bus

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning): WB_N_MASTERS_g, 2, master count (1..8).
REQ-002 The block SHALL take WB_N_SLAVES_g, 4, slave count (1..16).
REQ-003 The block SHALL take WB_AWIDTH_g, 16, address width.
REQ-004 The block SHALL take WB_DWIDTH_g, 8, data width (multiple of 8); SEL width = WB_DWIDTH_g/8.
REQ-005 The block SHALL take WB_BASEADDR_g, {16'h0030,16'h0020,16'h0010,16'h0000}, flat per-slave base addresses, slave 0 in LSBs.
REQ-006 The block SHALL take WB_SIZE_g, {4{16'h0010}}, flat per-slave window sizes, each a power of two, base aligned to size.
REQ-007 The block SHALL take WB_TIMEOUT_g, 15, cycles a strobed access may wait before forced error (>=1).
REQ-008 The block SHALL have these ports (name  direction  width  meaning): CLK_i  in  1  clock; RST_i  in  1  asynchronous active-high reset.
REQ-009 CLK_EN_i  in  1  clock enable for all state.
REQ-010 Master side, flat vectors, master m in slice m: WBM_ADR_i in N_M*AW; WBM_DAT_i in N_M*DW; WBM_SEL_i in N_M*SW; WBM_WE_i, WBM_STB_i, WBM_CYC_i in N_M; WBM_DAT_o out DW (shared); WBM_ACK_o, WBM_ERR_o, WBM_RTY_o out N_M; WBM_GNT_o out N_M one-hot grant.
REQ-011 Slave side: WBS_ADR_o out AW (offset within window); WBS_DAT_o out DW; WBS_SEL_o out SW; WBS_WE_o out 1; WBS_STB_o, WBS_CYC_o out N_S; WBS_DAT_i in N_S*DW; WBS_ACK_i, WBS_ERR_i, WBS_RTY_i in N_S.

Function
REQ-012 FSM SHALL have states IDLE, BUSY, ERR_RESP; all registered updates occur only when CLK_EN_i=1.
REQ-013 IDLE: if any WBM_CYC_i high, grant SHALL be registered round-robin, starting search at master (last_grant+1) mod N_M; transition to BUSY; one cycle grant latency.
REQ-014 BUSY: grant SHALL be held while granted master's CYC=1; on CYC=0, the next edge SHALL return to IDLE and update last_grant; no re-arbitration mid-cycle.
REQ-015 Decode SHALL be combinational on granted master's address: hit[s] = (ADR & ~(size_s-1)) == base_s; on overlap, lowest index wins; WBS_ADR_o = ADR & (size_s-1); unmapped gives WBS_ADR_o=0.
REQ-016 Only the decoded slave SHALL see STB/CYC = granted master's STB/CYC; ADR/DAT/SEL/WE forwarded from granted master; all zero when no grant.
REQ-017 Granted master SHALL receive decoded slave's ACK/ERR/RTY and DAT; non-granted masters SHALL see ACK/ERR/RTY=0; WBM_DAT_o=0 with no hit.
REQ-018 Unmapped address with STB=1 in BUSY SHALL enter ERR_RESP: WBM_ERR_o high exactly one cycle, no slave strobed, then back to BUSY.
REQ-019 Timeout counter (width clog2(WB_TIMEOUT_g+1)) SHALL count cycles with STB=1 and no ACK/ERR/RTY; clears on termination, STB=0 or IDLE; reaching WB_TIMEOUT_g SHALL enter ERR_RESP with slave STB/CYC masked that cycle.
REQ-020 Simultaneous slave termination and timeout expiry: slave termination SHALL win, counter cleared.
REQ-021 CLK_EN_i=0 SHALL freeze state, grant, pointer and counter; combinational routing stays live.

Reset
REQ-022 RST_i=1 SHALL asynchronously force IDLE, grant=0, last_grant=N_M-1 (so master 0 is first), counter=0.
REQ-023 During and immediately after reset every output SHALL be 0; reset mid-transfer aborts it with no ACK/ERR issued.

Structure
REQ-024 A shared package SHALL hold the FSM state enum and a clog2 helper function; memory-map defaults stay parameters.
REQ-025 Round-robin arbitration SHALL be a sub-module wb_rr_arbiter (req, ack-advance, one-hot grant, parameter N).

Verification
REQ-026 M0 and M1 both raise CYC from reset -> M0 granted first cycle after; M0 drops CYC -> M1 granted two edges later; WBM_GNT_o=01 then 10.
REQ-027 Granted master reads ADR=16'h0023 -> WBS_STB_o=0100, WBS_ADR_o=16'h0003, slave 2 returns 8'hA5 with ACK -> WBM_DAT_o=8'hA5, ACK to that master only.
REQ-028 ADR=16'h0050 with STB -> no WBS_STB_o bit set, WBM_ERR_o one cycle exactly, then BUSY.
REQ-029 Slave 1 never ACKs, WB_TIMEOUT_g=15 -> ERR asserted to master on 16th strobed cycle, WBS_STB_o masked that cycle.
REQ-030 Assert RST_i mid-access with ACK pending -> all outputs 0 immediately, no ACK seen; after release master 0 wins first.
REQ-031 Hold CLK_EN_i=0 for 5 cycles during timeout wait -> counter frozen, expiry delayed by exactly 5 cycles.
